// File: rtl/neural_mac_unit.sv
// Streaming neuron evaluator: accumulates bias + sum(x*w) over up to N_MAX terms,
// then presents a floor-shifted, saturated fixed-point result with a step activation.
module neural_mac_unit #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int N_MAX = 4,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_coeff,
  input  logic             in_last,
  input  logic [WIDTH-1:0] bias,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_fire
);

  localparam int CNT_W = $clog2(N_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [WIDTH-1:0]         out_sum_q, out_sum_d;
  logic                     out_fire_q, out_fire_d;

  logic                     accept;
  logic                     final_term;
  logic [CNT_W-1:0]         term_idx;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  shifted;
  logic [ACC_W-WIDTH:0]     sat_hi;
  logic                     overflow;
  logic [WIDTH-1:0]         sat_val;

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = out_sum_q;
  assign out_fire  = out_fire_q;

  assign accept     = in_valid && in_ready;
  // The term about to be accepted is number 1 from IDLE, otherwise one past the count.
  assign term_idx   = (state_q == IDLE) ? CNT_W'(1) : count_q + CNT_W'(1);
  assign final_term = in_last || (term_idx == CNT_W'(N_MAX));

  // Accumulator runs at 2*FRAC fractional bits; bias is lifted by FRAC to match.
  always_comb begin
    prod     = $signed(in_data) * $signed(in_coeff);
    prod_ext = ACC_W'(prod);
    bias_ext = ACC_W'($signed(bias)) <<< FRAC;
    acc_sum  = (state_q == IDLE) ? (bias_ext + prod_ext) : (acc_q + prod_ext);
    shifted  = acc_sum >>> FRAC;
    // In range only if every bit from the result sign upwards agrees.
    sat_hi   = shifted[ACC_W-1:WIDTH-1];
    overflow = !((&sat_hi) || !(|sat_hi));
    if (overflow) begin
      sat_val = shifted[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sat_val = shifted[WIDTH-1:0];
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    out_sum_d  = out_sum_q;
    out_fire_d = out_fire_q;

    unique case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          acc_d   = acc_sum;
          count_d = term_idx;
          if (final_term) begin
            state_d    = DONE;
            out_sum_d  = sat_val;
            out_fire_d = !sat_val[WIDTH-1] && (|sat_val);
          end else begin
            state_d = ACC;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      count_q    <= '0;
      out_sum_q  <= '0;
      out_fire_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      out_sum_q  <= out_sum_d;
      out_fire_q <= out_fire_d;
    end
  end

endmodule

// File: tb/tb_neural_mac_unit.sv
// Directed bench for neural_mac_unit (WIDTH=16, FRAC=8, N_MAX=4) with hand-computed results.
module tb_neural_mac_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] in_coeff;
  logic        in_last;
  logic [15:0] bias;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_fire;

  int n_checks = 0;
  int n_errors = 0;

  neural_mac_unit #(
    .WIDTH(16),
    .FRAC (8),
    .N_MAX(4),
    .ACC_W(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_coeff (in_coeff),
    .in_last  (in_last),
    .bias     (bias),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_fire (out_fire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one term from a falling edge and wait until a rising edge accepts it.
  task automatic send(input logic [15:0] d, input logic [15:0] c, input logic l,
                      input logic [15:0] b);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_coeff = c;
    in_last  = l;
    bias     = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("pop_valid", 32'(out_valid), 32'd0);
    check("pop_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_coeff  = '0;
    in_last   = 1'b0;
    bias      = '0;
    out_ready = 1'b0;

    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sum",   32'(out_sum),   32'h0);
    check("rst_fire",  32'(out_fire),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(in_ready), 32'd1);

    // 2.0*1.5 + 1.0*(-1.0) = 2.0
    send(16'h0200, 16'h0180, 1'b0, 16'h0000);
    check("t1_mid_valid", 32'(out_valid), 32'd0);
    send(16'h0100, 16'hFF00, 1'b1, 16'h0000);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_ready", 32'(in_ready),  32'd0);
    check("t1_sum",   32'(out_sum),   32'h0200);
    check("t1_fire",  32'(out_fire),  32'd1);
    pop();

    // 1.0 + 1.0*(-1.0) = 0, no fire; unit stays busy until consumed
    send(16'h0100, 16'hFF00, 1'b1, 16'h0100);
    check("t2_sum",  32'(out_sum),  32'h0000);
    check("t2_fire", 32'(out_fire), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_hold_ready", 32'(in_ready), 32'd0);
    end
    pop();

    // Positive saturation: 2*0x3FFF0001 >>> 8 far above 0x7FFF
    send(16'h7FFF, 16'h7FFF, 1'b0, 16'h0000);
    send(16'h7FFF, 16'h7FFF, 1'b1, 16'h0000);
    check("t3a_sum",  32'(out_sum),  32'h7FFF);
    check("t3a_fire", 32'(out_fire), 32'd1);
    pop();

    // Negative saturation: 2*(-0x3FFF8000) >>> 8 far below -0x8000
    send(16'h7FFF, 16'h8000, 1'b0, 16'h0000);
    send(16'h7FFF, 16'h8000, 1'b1, 16'h0000);
    check("t3b_sum",  32'(out_sum),  32'h8000);
    check("t3b_fire", 32'(out_fire), 32'd0);
    pop();

    // Forced termination after four 1.0*1.0 terms, then a pending fifth term
    for (int i = 0; i < 4; i++) begin
      send(16'h0100, 16'h0100, 1'b0, 16'h0000);
      check("t4_valid_step", 32'(out_valid), (i == 3) ? 32'd1 : 32'd0);
    end
    check("t4_sum",  32'(out_sum),  32'h0400);
    check("t4_fire", 32'(out_fire), 32'd1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h0300;
    in_coeff = 16'h0100;
    in_last  = 1'b1;
    bias     = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_bp_sum",   32'(out_sum),   32'h0400);
      check("t4_bp_valid", 32'(out_valid), 32'd1);
      check("t4_bp_ready", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("t4_no_same_edge", 32'(out_valid), 32'd0);
    check("t4_ready_again",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("t4_fifth_valid", 32'(out_valid), 32'd1);
    check("t4_fifth_sum",   32'(out_sum),   32'h0300);
    pop();

    // Asynchronous reset in the middle of an evaluation discards the partial sum
    send(16'h0100, 16'h0100, 1'b0, 16'h0500);
    send(16'h0100, 16'h0100, 1'b0, 16'h0500);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_ready", 32'(in_ready),  32'd1);
    #1;
    rst = 1'b0;
    send(16'h0100, 16'h0100, 1'b1, 16'h0000);
    check("t5_sum",  32'(out_sum),  32'h0100);
    check("t5_fire", 32'(out_fire), 32'd1);

    // Asynchronous reset while a result is held clears it without a clock edge
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_sum",   32'(out_sum),   32'h0);
    check("t6_rst_fire",  32'(out_fire),  32'd0);
    #1;
    rst = 1'b0;
    send(16'h0080, 16'h0200, 1'b1, 16'hFF00);
    check("t6_sum",  32'(out_sum),  32'h0000);
    check("t6_fire", 32'(out_fire), 32'd0);
    pop();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
